// File: rtl/gen_delay_chain_if.sv
// Handshake/data bundle for gen_delay_chain: the control strobes and channel
// inputs go in, and the delayed data, valid flag and packed edge counters come out.
interface gen_delay_chain_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic                   en;
  logic                   flush;
  logic                   cnt_clr;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   b_valid;
  logic [WIDTH*CNT_W-1:0] edge_cnt;

  modport master (output en, flush, cnt_clr, a, input b, b_valid, edge_cnt);
  modport slave  (input en, flush, cnt_clr, a, output b, b_valid, edge_cnt);
endinterface

// File: rtl/gen_delay_chain.sv
// WIDTH-channel DEPTH-stage delay chain with a fill FSM and saturating per-channel edge counters.
// Define GEN_DELAY_ANY_EDGE_EN to count both edges of b instead of rising edges only.
module gen_delay_chain #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3,
  parameter int CNT_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  gen_delay_chain_if.slave  bus
);
  localparam int                FILL_W    = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH);

  typedef enum logic {FILL, RUN} state_t;

  state_t            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              b_valid_q, b_valid_d;
  logic              shift;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign shift = bus.en & ~bus.flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FILL;
      fill_q    <= '0;
      b_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      b_valid_q <= b_valid_d;
    end
  end

  // Fill count only moves while filling; once in RUN it simply holds.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (bus.flush) begin
      state_d = FILL;
      fill_d  = '0;
    end else if (bus.en && state_q == FILL) begin
      fill_d = fill_q + 1'b1;
      if (fill_d == FILL_LAST) state_d = RUN;
    end
  end

  always_comb begin
    b_valid_d = (state_d == RUN);
  end

  assign bus.b_valid = b_valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [DEPTH-1:0] stage_q, stage_d;
    logic [CNT_W-1:0] cnt_q;
    logic             evt;

    // Bit k is stage k; the top bit is the channel output.
    assign stage_d = DEPTH'({stage_q, bus.a[i]});

`ifdef GEN_DELAY_ANY_EDGE_EN
    assign evt = shift && (state_d == RUN) && (stage_d[DEPTH-1] != stage_q[DEPTH-1]);
`else
    assign evt = shift && (state_d == RUN) && stage_d[DEPTH-1] && !stage_q[DEPTH-1];
`endif

    always_ff @(posedge clock or posedge reset) begin
      if (reset)          stage_q <= '0;
      else if (bus.flush) stage_q <= '0;
      else if (bus.en)    stage_q <= stage_d;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset)            cnt_q <= '0;
      else if (bus.cnt_clr) cnt_q <= '0;
      else if (evt)         cnt_q <= sat_inc(cnt_q);
    end

    assign bus.b[i]                       = stage_q[DEPTH-1];
    assign bus.edge_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
endmodule

// File: tb/tb_gen_delay_chain.sv
// Directed self-checking bench for gen_delay_chain (WIDTH=4, DEPTH=3, CNT_W=4),
// with edge-count expectations that follow GEN_DELAY_ANY_EDGE_EN.
module tb_gen_delay_chain;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  gen_delay_chain_if #(.WIDTH(4), .CNT_W(4)) bus ();

  gen_delay_chain #(.WIDTH(4), .DEPTH(3), .CNT_W(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.en = 1'b0; bus.flush = 1'b0; bus.cnt_clr = 1'b0; bus.a = 4'h0;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.flush = 1'b0; bus.cnt_clr = 1'b0; bus.a = 4'h0;
    rst = 1'b1;
    tick();
    if (bus.b !== 4'h0) begin n_fail++; $display("FAIL rst_b: got %h want 0", bus.b); end
    n_chk++;
    if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.b_valid); end
    n_chk++;
    if (bus.edge_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0000", bus.edge_cnt); end
    n_chk++;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [15:0] exp_cnt;
    do_reset();
    bus.en = 1'b1; bus.a = 4'hA;
    tick();
    bus.a = 4'h0;
    tick();
    if (bus.b !== 4'h0 || bus.b_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_c2: b=%h valid=%b want 0/0", bus.b, bus.b_valid);
    end
    n_chk++;
    tick();
    if (bus.b !== 4'hA) begin n_fail++; $display("FAIL lat_b3: got %h want a", bus.b); end
    n_chk++;
    if (bus.b_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid3: got %b want 1", bus.b_valid); end
    n_chk++;
    if (bus.edge_cnt !== 16'h1010) begin n_fail++; $display("FAIL lat_cnt3: got %h want 1010", bus.edge_cnt); end
    n_chk++;
    tick();
    if (bus.b !== 4'h0) begin n_fail++; $display("FAIL lat_b4: got %h want 0", bus.b); end
    n_chk++;
`ifdef GEN_DELAY_ANY_EDGE_EN
    exp_cnt = 16'h2020;
`else
    exp_cnt = 16'h1010;
`endif
    if (bus.edge_cnt !== exp_cnt) begin n_fail++; $display("FAIL lat_cnt4: got %h want %h", bus.edge_cnt, exp_cnt); end
    n_chk++;
  endtask

  task automatic test_stall();
    do_reset();
    bus.en = 1'b1; bus.a = 4'hA;
    tick();
    bus.en = 1'b0; bus.a = 4'h0;
    tick();
    tick();
    if (bus.b !== 4'h0 || bus.b_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold: b=%h valid=%b want 0/0", bus.b, bus.b_valid);
    end
    n_chk++;
    bus.en = 1'b1;
    tick();
    if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid2: got %b want 0", bus.b_valid); end
    n_chk++;
    tick();
    if (bus.b !== 4'hA || bus.b_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_c5: b=%h valid=%b want a/1", bus.b, bus.b_valid);
    end
    n_chk++;
  endtask

  task automatic test_flush();
    do_reset();
    bus.en = 1'b1; bus.a = 4'hF;
    tick(); tick(); tick();
    if (bus.edge_cnt !== 16'h1111) begin n_fail++; $display("FAIL fl_pre: got %h want 1111", bus.edge_cnt); end
    n_chk++;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick(); tick();
    bus.flush = 1'b1;
    tick();
    if (bus.b !== 4'h0 || bus.b_valid !== 1'b0) begin
      n_fail++; $display("FAIL fl_clear: b=%h valid=%b want 0/0", bus.b, bus.b_valid);
    end
    n_chk++;
    if (bus.edge_cnt !== 16'h1111) begin n_fail++; $display("FAIL fl_cnt: got %h want 1111", bus.edge_cnt); end
    n_chk++;
    bus.flush = 1'b0;
    tick(); tick();
    if (bus.b !== 4'h0 || bus.b_valid !== 1'b0) begin
      n_fail++; $display("FAIL fl_refill: b=%h valid=%b want 0/0", bus.b, bus.b_valid);
    end
    n_chk++;
    tick();
    if (bus.b !== 4'hF || bus.b_valid !== 1'b1) begin
      n_fail++; $display("FAIL fl_emerge: b=%h valid=%b want f/1", bus.b, bus.b_valid);
    end
    n_chk++;
    if (bus.edge_cnt !== 16'h2222) begin n_fail++; $display("FAIL fl_cnt2: got %h want 2222", bus.edge_cnt); end
    n_chk++;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.en = 1'b1; bus.a = 4'h0;
    tick(); tick(); tick();
    for (int i = 0; i < 40; i++) begin
      bus.a = (i % 2 == 0) ? 4'h1 : 4'h0;
      tick();
    end
    bus.a = 4'h0;
    if (bus.edge_cnt[3:0] !== 4'hF) begin n_fail++; $display("FAIL sat_ch0: got %h want f", bus.edge_cnt[3:0]); end
    n_chk++;
    if (bus.edge_cnt[15:4] !== 12'h0) begin n_fail++; $display("FAIL sat_others: got %h want 000", bus.edge_cnt[15:4]); end
    n_chk++;
  endtask

  task automatic test_clr_vs_event();
    logic [3:0] exp_c1;
    do_reset();
    bus.en = 1'b1; bus.a = 4'h0;
    tick(); tick(); tick();
    bus.a = 4'h2;
    tick();
    bus.a = 4'h0;
    tick();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    if (bus.b[1] !== 1'b1) begin n_fail++; $display("FAIL clr_b1: got %b want 1", bus.b[1]); end
    n_chk++;
    if (bus.edge_cnt[7:4] !== 4'h0) begin n_fail++; $display("FAIL clr_cnt: got %h want 0", bus.edge_cnt[7:4]); end
    n_chk++;
    bus.a = 4'h2;
    tick();
    bus.a = 4'h0;
    tick(); tick();
`ifdef GEN_DELAY_ANY_EDGE_EN
    exp_c1 = 4'h2;
`else
    exp_c1 = 4'h1;
`endif
    if (bus.edge_cnt[7:4] !== exp_c1) begin n_fail++; $display("FAIL clr_next: got %h want %h", bus.edge_cnt[7:4], exp_c1); end
    n_chk++;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.en = 1'b1; bus.a = 4'hF;
    tick(); tick(); tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (bus.b !== 4'h0 || bus.b_valid !== 1'b0 || bus.edge_cnt !== 16'h0) begin
      n_fail++; $display("FAIL arst_now: b=%h valid=%b cnt=%h want 0/0/0000", bus.b, bus.b_valid, bus.edge_cnt);
    end
    n_chk++;
    #1;
    rst = 1'b0;
    tick(); tick();
    if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL arst_fill: got %b want 0", bus.b_valid); end
    n_chk++;
    tick();
    if (bus.b_valid !== 1'b1 || bus.b !== 4'hF) begin
      n_fail++; $display("FAIL arst_run: b=%h valid=%b want f/1", bus.b, bus.b_valid);
    end
    n_chk++;
  endtask

  task automatic test_pulse_edges();
    logic [3:0] exp_c2;
    do_reset();
    bus.en = 1'b1; bus.a = 4'h0;
    tick(); tick(); tick();
    bus.a = 4'h4;
    tick();
    bus.a = 4'h0;
    tick(); tick(); tick();
    if (bus.b !== 4'h0) begin n_fail++; $display("FAIL pulse_b: got %h want 0", bus.b); end
    n_chk++;
`ifdef GEN_DELAY_ANY_EDGE_EN
    exp_c2 = 4'h2;
`else
    exp_c2 = 4'h1;
`endif
    if (bus.edge_cnt[11:8] !== exp_c2) begin n_fail++; $display("FAIL pulse_cnt: got %h want %h", bus.edge_cnt[11:8], exp_c2); end
    n_chk++;
  endtask

  initial begin
    bus.en = 1'b0; bus.flush = 1'b0; bus.cnt_clr = 1'b0; bus.a = 4'h0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_saturation();
    test_clr_vs_event();
    test_async_reset();
    test_pulse_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
